shader_program_loader: RTL and testbench

Frame-synchronous program update controller for the shader instruction memory. Collects instruction bytes delivered by the SPI receiver into a NUM_INSTR-deep staging buffer, and on a commit request waits for the next frame boundary. It then streams the complete program into the shader memory in one burst of back-to-back cycles. Sits between spi_receiver and shader_memory, replacing the direct memory_load/memory_shift path, so a program never changes mid-frame and partial programs never reach the execute unit.

---
 rtl/shader_program_loader.sv | 139 +++++++++++++
 tb/tb_shader_program_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shader_program_loader.sv
// Frame-synchronous shader program loader: stages SPI instruction bytes and, after a
// commit, bursts the complete program into shader memory on the next frame boundary.
module shader_program_loader #(
    parameter int NUM_INSTR = 12,
    parameter int INSTR_W   = 8,
    localparam int CW       = $clog2(NUM_INSTR + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               instr_valid_i,
    input  logic               commit_i,
    input  logic               clear_i,
    input  logic               next_frame_i,
    output logic [INSTR_W-1:0] mem_instr_o,
    output logic               mem_load_o,
    output logic               mem_shift_o,
    output logic [CW-1:0]      staged_count_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               reject_o,
    output logic               overflow_o
);
    typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_e;

    localparam logic [CW-1:0] FULL = CW'(NUM_INSTR);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d, idx_q, idx_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                load_q, load_d, busy_q, busy_d;
    logic                done_q, done_d, reject_q, reject_d, ov_q, ov_d;
    logic                we;
    logic [INSTR_W-1:0]  staging [NUM_INSTR];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        ov_d     = ov_q;
        instr_d  = '0;
        load_d   = 1'b0;
        done_d   = 1'b0;
        reject_d = 1'b0;
        we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_i) begin
                    count_d = '0;
                    ov_d    = 1'b0;
                end else begin
                    if (instr_valid_i) begin
                        if (count_q < FULL) begin
                            we      = 1'b1;
                            count_d = count_q + ONE;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end
                    // The commit sees the count including a byte staged this same cycle.
                    if (commit_i) begin
                        if (count_d == FULL) state_d  = ARMED;
                        else                 reject_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (clear_i) begin
                    state_d = IDLE;
                    count_d = '0;
                    ov_d    = 1'b0;
                end else begin
                    if (instr_valid_i) ov_d = 1'b1;
                    if (next_frame_i) begin
                        state_d = WRITE;
                        load_d  = 1'b1;
                        instr_d = staging[0];
                        idx_d   = ONE;
                    end
                end
            end
            WRITE: begin
                if (idx_q == FULL) begin
                    state_d = IDLE;
                    count_d = '0;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    ov_d    = 1'b0;
                end else begin
                    if (instr_valid_i) ov_d = 1'b1;
                    load_d  = 1'b1;
                    instr_d = staging[idx_q];
                    idx_d   = idx_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            instr_q  <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            instr_q  <= instr_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            reject_q <= reject_d;
            ov_q     <= ov_d;
        end
    end

    // Staging contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk_i) begin
        if (we) staging[count_q] <= instr_i;
    end

    assign mem_instr_o    = instr_q;
    assign mem_load_o     = load_q;
    assign mem_shift_o    = load_q;
    assign staged_count_o = count_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign reject_o       = reject_q;
    assign overflow_o     = ov_q;
endmodule

// File: tb/tb_shader_program_loader.sv
// Directed bench for shader_program_loader: install, reject, overflow, same-cycle, abort, reset.
module tb_shader_program_loader;
    localparam int N = 12;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] instr = '0;
    logic         valid = 1'b0, commit = 1'b0, clear = 1'b0, nf = 1'b0;
    logic [W-1:0] mem_instr;
    logic         mem_load, mem_shift, busy, done, reject, ovf;
    logic [3:0]   cnt;

    int errs = 0;
    int checks = 0;
    logic [W-1:0] exp_mem [N];
    int mcnt = 0;

    shader_program_loader #(.NUM_INSTR(N), .INSTR_W(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .instr_valid_i(valid),
        .commit_i(commit), .clear_i(clear), .next_frame_i(nf),
        .mem_instr_o(mem_instr), .mem_load_o(mem_load), .mem_shift_o(mem_shift),
        .staged_count_o(cnt), .busy_o(busy), .done_o(done), .reject_o(reject),
        .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stage one byte; the bench model records it only while there is room.
    task automatic send_byte(input logic [W-1:0] b, input logic with_commit);
        instr = b; valid = 1'b1; commit = with_commit;
        if (mcnt < N) begin exp_mem[mcnt] = b; mcnt++; end
        tick();
        valid = 1'b0; commit = 1'b0;
    endtask

    task automatic stage_n(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(base + W'(i), 1'b0);
    endtask

    task automatic pulse_commit();
        commit = 1'b1; tick(); commit = 1'b0;
    endtask

    // Pulse next_frame and check every burst cycle plus the done cycle.
    task automatic run_burst(input string name);
        nf = 1'b1; tick(); nf = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (mem_load !== 1'b1 || mem_shift !== 1'b1 || mem_instr !== exp_mem[k]) begin
                errs++;
                $display("FAIL %s beat%0d: load=%b shift=%b instr=%h, required 1 1 %h",
                         name, k, mem_load, mem_shift, mem_instr, exp_mem[k]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cnt !== 4'd0 || mem_load !== 1'b0 || ovf !== 1'b0) begin
            errs++;
            $display("FAIL %s done: done=%b busy=%b cnt=%0d load=%b ovf=%b, required 1 0 0 0 0",
                     name, done, busy, cnt, mem_load, ovf);
        end
        mcnt = 0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errs++; $display("FAIL %s done_pulse: done=%b, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #12;
        checks++;
        if ({mem_instr, mem_load, mem_shift, cnt, busy, done, reject, ovf} !== '0) begin
            errs++;
            $display("FAIL reset: instr=%h load=%b shift=%b cnt=%0d busy=%b done=%b rej=%b ovf=%b, required all 0",
                     mem_instr, mem_load, mem_shift, cnt, busy, done, reject, ovf);
        end
        rst_n = 1'b1; tick();
    endtask

    task automatic test_normal();
        stage_n(8'h10, N);
        checks++;
        if (cnt !== 4'd12) begin errs++; $display("FAIL normal_count: cnt=%0d, required 12", cnt); end
        pulse_commit();
        checks++;
        if (busy !== 1'b1 || reject !== 1'b0 || mem_load !== 1'b0) begin
            errs++; $display("FAIL normal_armed: busy=%b rej=%b load=%b, required 1 0 0", busy, reject, mem_load);
        end
        run_burst("normal");
    endtask

    task automatic test_short();
        stage_n(8'h20, 5);
        pulse_commit();
        checks++;
        if (reject !== 1'b1 || busy !== 1'b0 || cnt !== 4'd5) begin
            errs++; $display("FAIL short_reject: rej=%b busy=%b cnt=%0d, required 1 0 5", reject, busy, cnt);
        end
        tick();
        checks++;
        if (reject !== 1'b0) begin errs++; $display("FAIL short_reject_pulse: rej=%b, required 0", reject); end
        stage_n(8'h25, 6);
        send_byte(8'h2B, 1'b1);
        checks++;
        if (busy !== 1'b1 || reject !== 1'b0 || cnt !== 4'd12) begin
            errs++; $display("FAIL short_byte_commit: busy=%b rej=%b cnt=%0d, required 1 0 12", busy, reject, cnt);
        end
        run_burst("short");
    endtask

    task automatic test_overflow();
        stage_n(8'h40, N);
        send_byte(8'hEE, 1'b0);
        checks++;
        if (cnt !== 4'd12 || ovf !== 1'b1) begin
            errs++; $display("FAIL ovf_full: cnt=%0d ovf=%b, required 12 1", cnt, ovf);
        end
        pulse_commit();
        run_burst("ovf_full");
        stage_n(8'h50, N);
        pulse_commit();
        checks++;
        if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_pre_armed: ovf=%b, required 0", ovf); end
        instr = 8'hDD; valid = 1'b1; tick(); valid = 1'b0;
        checks++;
        if (ovf !== 1'b1 || cnt !== 4'd12 || busy !== 1'b1) begin
            errs++; $display("FAIL ovf_armed: ovf=%b cnt=%0d busy=%b, required 1 12 1", ovf, cnt, busy);
        end
        run_burst("ovf_armed");
    endtask

    task automatic test_same_cycle();
        stage_n(8'h60, N);
        commit = 1'b1; nf = 1'b1; tick(); commit = 1'b0; nf = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b1 || mem_load !== 1'b0) begin
            errs++; $display("FAIL same_commit_nf: busy=%b load=%b, required 1 0", busy, mem_load);
        end
        run_burst("same_commit_nf");
        stage_n(8'h70, 3);
        clear = 1'b1; commit = 1'b1; tick(); clear = 1'b0; commit = 1'b0;
        mcnt = 0;
        checks++;
        if (cnt !== 4'd0 || reject !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL same_clear_commit: cnt=%0d rej=%b busy=%b, required 0 0 0", cnt, reject, busy);
        end
        stage_n(8'h78, N);
        send_byte(8'h99, 1'b0);
        clear = 1'b1; instr = 8'h11; valid = 1'b1; tick(); clear = 1'b0; valid = 1'b0;
        mcnt = 0;
        checks++;
        if (cnt !== 4'd0 || ovf !== 1'b0) begin
            errs++; $display("FAIL same_clear_valid: cnt=%0d ovf=%b, required 0 0", cnt, ovf);
        end
    endtask

    task automatic test_abort();
        int loads;
        stage_n(8'h80, N);
        pulse_commit();
        clear = 1'b1; tick(); clear = 1'b0;
        mcnt = 0;
        checks++;
        if (busy !== 1'b0 || cnt !== 4'd0) begin
            errs++; $display("FAIL abort_clear: busy=%b cnt=%0d, required 0 0", busy, cnt);
        end
        loads = 0;
        nf = 1'b1; tick(); nf = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            if (mem_load !== 1'b0 || done !== 1'b0) loads++;
            tick();
        end
        checks++;
        if (loads !== 0) begin errs++; $display("FAIL abort_no_burst: active cycles=%0d, required 0", loads); end
    endtask

    task automatic test_reset_mid_write();
        stage_n(8'hA0, N);
        pulse_commit();
        nf = 1'b1; tick(); nf = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (mem_load !== 1'b1 || mem_instr !== 8'hA6) begin
            errs++; $display("FAIL rst_mid_beat6: load=%b instr=%h, required 1 a6", mem_load, mem_instr);
        end
        rst_n = 1'b0; #1;
        checks++;
        if ({mem_instr, mem_load, mem_shift, cnt, busy, done, reject, ovf} !== '0) begin
            errs++;
            $display("FAIL rst_mid_outputs: instr=%h load=%b cnt=%0d busy=%b, required all 0",
                     mem_instr, mem_load, cnt, busy);
        end
        mcnt = 0;
        tick(); rst_n = 1'b1; tick();
        stage_n(8'hB0, N);
        pulse_commit();
        checks++;
        if (busy !== 1'b1) begin errs++; $display("FAIL rst_mid_recommit: busy=%b, required 1", busy); end
        run_burst("rst_mid_fresh");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_short();
        test_overflow();
        test_same_cycle();
        test_abort();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
